// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg
//   Shared definitions for the two-requester multiplier arbiter: FSM state
//   encoding, operand/result widths, wait-counter width and the default
//   abort timeout.
package mul_arb_pkg;

  localparam int OPERAND_W       = 32;
  localparam int RESULT_W        = 64;
  localparam int CNT_W           = 7;
  localparam int TIMEOUT_DEFAULT = 100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
//   Two-way round-robin grant logic. Grants are combinational; the
//   last-grant pointer only moves when the granted request is accepted.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   req[1:0]    - request lines (already qualified by the caller)
//   accept      - the current grant was taken this cycle
//   grant[1:0]  - one-hot (or zero) grant
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  // 1 means requester 1 was granted last, so requester 0 wins the next tie.
  logic last_grant_reg;

  always_comb begin
    grant    = 2'b00;
    grant[0] = req[0] & (~req[1] | last_grant_reg);
    grant[1] = req[1] & (~req[0] | ~last_grant_reg);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= 1'b1;
    end else if (accept) begin
      last_grant_reg <= grant[1];
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter
//   Shares one iterative multiplier between two requesters. An accepted
//   operation drives mul_op_start until the multiplier reports done (or the
//   wait counter expires), then a single CLEAR cycle pulses mul_op_clear
//   before the next request can be taken.
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   reqN_valid/ready/multiplier/
//   reqN_multiplicand                - requester N handshake and operands
//   resp_valid/id/result/error       - response pulse, owner, product, abort
//   mul_multiplier/multiplicand      - operands to the shared multiplier
//   mul_op_start/mul_op_clear        - start level / clear pulse
//   mul_op_done/mul_result           - multiplier done level and product
//   busy                             - high whenever not IDLE
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [OPERAND_W-1:0] req0_multiplier,
  input  logic [OPERAND_W-1:0] req0_multiplicand,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [OPERAND_W-1:0] req1_multiplier,
  input  logic [OPERAND_W-1:0] req1_multiplicand,
  output logic                 resp_valid,
  output logic                 resp_id,
  output logic [RESULT_W-1:0]  resp_result,
  output logic                 resp_error,
  output logic [OPERAND_W-1:0] mul_multiplier,
  output logic [OPERAND_W-1:0] mul_multiplicand,
  output logic                 mul_op_start,
  output logic                 mul_op_clear,
  input  logic                 mul_op_done,
  input  logic [RESULT_W-1:0]  mul_result,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             op_id_reg;

  logic [1:0] valid_vec;
  logic [1:0] arb_req;
  logic [1:0] grant_vec;
  logic [1:0] ready_vec;
  logic       arb_open;
  logic       accept;
  logic       accept_id;
  logic [OPERAND_W-1:0] sel_multiplier;
  logic [OPERAND_W-1:0] sel_multiplicand;

  assign valid_vec = {req1_valid, req0_valid};

  // Ready is withheld while reset is asserted so every output reads 0 then.
  assign arb_open = (state_reg == ST_IDLE) && !reset;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign arb_req[gi]   = valid_vec[gi] & arb_open;
      assign ready_vec[gi] = grant_vec[gi];
    end
  endgenerate

  rr_arbiter2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    (arb_req),
    .accept (accept),
    .grant  (grant_vec)
  );

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];

  assign accept    = |(valid_vec & ready_vec);
  assign accept_id = ready_vec[1];

  assign sel_multiplier   = accept_id ? req1_multiplier   : req0_multiplier;
  assign sel_multiplicand = accept_id ? req1_multiplicand : req0_multiplicand;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      cnt_reg          <= '0;
      op_id_reg        <= 1'b0;
      resp_valid       <= 1'b0;
      resp_id          <= 1'b0;
      resp_result      <= '0;
      resp_error       <= 1'b0;
      mul_multiplier   <= '0;
      mul_multiplicand <= '0;
      mul_op_start     <= 1'b0;
      mul_op_clear     <= 1'b0;
      busy             <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            mul_multiplier   <= sel_multiplier;
            mul_multiplicand <= sel_multiplicand;
            op_id_reg        <= accept_id;
            cnt_reg          <= '0;
            mul_op_start     <= 1'b1;
            busy             <= 1'b1;
            state_reg        <= ST_RUN;
          end
        end

        ST_RUN: begin
          // Done is checked first so a done arriving on the last wait
          // cycle still produces a good result.
          if (mul_op_done) begin
            resp_result  <= mul_result;
            resp_error   <= 1'b0;
            resp_id      <= op_id_reg;
            resp_valid   <= 1'b1;
            mul_op_start <= 1'b0;
            mul_op_clear <= 1'b1;
            state_reg    <= ST_CLEAR;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            resp_result  <= '0;
            resp_error   <= 1'b1;
            resp_id      <= op_id_reg;
            resp_valid   <= 1'b1;
            mul_op_start <= 1'b0;
            mul_op_clear <= 1'b1;
            state_reg    <= ST_CLEAR;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        ST_CLEAR: begin
          mul_op_clear <= 1'b0;
          busy         <= 1'b0;
          state_reg    <= ST_IDLE;
        end

        default: begin
          mul_op_start <= 1'b0;
          mul_op_clear <= 1'b0;
          busy         <= 1'b0;
          state_reg    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter
//   Directed bench for mul_arbiter with a small latency-programmable
//   multiplier model. Expected products and cycle counts are hand-computed.
module tb_mul_arbiter;

  localparam int TIMEOUT = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [31:0] req0_multiplier = '0;
  logic [31:0] req0_multiplicand = '0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [31:0] req1_multiplier = '0;
  logic [31:0] req1_multiplicand = '0;
  logic        resp_valid;
  logic        resp_id;
  logic [63:0] resp_result;
  logic        resp_error;
  logic [31:0] mul_multiplier;
  logic [31:0] mul_multiplicand;
  logic        mul_op_start;
  logic        mul_op_clear;
  logic        mul_op_done = 1'b0;
  logic [63:0] mul_result = '0;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int lat_cfg = 0;
  logic [7:0] m_cnt = '0;

  mul_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk               (clk),
    .reset             (reset),
    .req0_valid        (req0_valid),
    .req0_ready        (req0_ready),
    .req0_multiplier   (req0_multiplier),
    .req0_multiplicand (req0_multiplicand),
    .req1_valid        (req1_valid),
    .req1_ready        (req1_ready),
    .req1_multiplier   (req1_multiplier),
    .req1_multiplicand (req1_multiplicand),
    .resp_valid        (resp_valid),
    .resp_id           (resp_id),
    .resp_result       (resp_result),
    .resp_error        (resp_error),
    .mul_multiplier    (mul_multiplier),
    .mul_multiplicand  (mul_multiplicand),
    .mul_op_start      (mul_op_start),
    .mul_op_clear      (mul_op_clear),
    .mul_op_done       (mul_op_done),
    .mul_result        (mul_result),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  // Multiplier model: raises done lat_cfg+1 cycles after start is first
  // seen, holds it until clear; lat_cfg of 200 never finishes in time.
  always @(posedge clk) begin
    if (reset || mul_op_clear) begin
      mul_op_done <= 1'b0;
      mul_result  <= '0;
      m_cnt       <= '0;
    end else if (mul_op_start && !mul_op_done) begin
      if (int'(m_cnt) == lat_cfg) begin
        mul_op_done <= 1'b1;
        mul_result  <= {32'd0, mul_multiplier} * {32'd0, mul_multiplicand};
      end else begin
        m_cnt <= m_cnt + 8'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 0;
    while (!resp_valid && cyc < 300) begin
      tick();
      cyc++;
    end
    if (!resp_valid) check("resp_wait_expired", 64'd0, 64'd1);
  endtask

  // Present one op from requester `who` in IDLE, take it, check RUN entry.
  task automatic start_op(input int who, input logic [31:0] a, input logic [31:0] b,
                          input int lat);
    lat_cfg = lat;
    if (who == 0) begin
      req0_valid = 1'b1; req0_multiplier = a; req0_multiplicand = b;
    end else begin
      req1_valid = 1'b1; req1_multiplier = a; req1_multiplicand = b;
    end
    #1;
    check("accept_ready", {62'd0, req1_ready, req0_ready}, (who == 0) ? 64'd1 : 64'd2);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("start_t1", 64'(mul_op_start), 64'd1);
    check("busy_run", 64'(busy), 64'd1);
    check("mul_a_t1", 64'(mul_multiplier), 64'(a));
    check("mul_b_t1", 64'(mul_multiplicand), 64'(b));
  endtask

  task automatic finish_op(input logic exp_id, input logic [63:0] exp_res, input logic exp_err,
                           input int exp_cyc, input logic [31:0] exp_a);
    int cyc;
    wait_resp(cyc);
    check("resp_latency", 64'(cyc), 64'(exp_cyc));
    check("resp_id", 64'(resp_id), 64'(exp_id));
    check("resp_result", resp_result, exp_res);
    check("resp_error", 64'(resp_error), 64'(exp_err));
    check("clear_pulse", 64'(mul_op_clear), 64'd1);
    check("start_low_clr", 64'(mul_op_start), 64'd0);
    check("mul_a_stable", 64'(mul_multiplier), 64'(exp_a));
    tick();
    check("resp_pulse_end", 64'(resp_valid), 64'd0);
    check("clear_end", 64'(mul_op_clear), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
    check("resp_hold", resp_result, exp_res);
  endtask

  initial begin
    int cyc;
    logic saw_resp;

    // Reset with a requester already valid: everything must read 0.
    reset = 1'b1;
    req0_valid = 1'b1;
    tick();
    tick();
    check("rst_ready0", 64'(req0_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_start", 64'(mul_op_start), 64'd0);
    check("rst_clear", 64'(mul_op_clear), 64'd0);
    check("rst_resp", {resp_result[61:0], resp_valid, resp_error}, 64'd0);
    req0_valid = 1'b0;
    reset = 1'b0;
    tick();

    // Contention from fresh reset: grants 0,1,0,1.
    req0_multiplier = 32'd3;  req0_multiplicand = 32'd5;
    req1_multiplier = 32'd11; req1_multiplicand = 32'd13;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    lat_cfg = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("cont_grant", {62'd0, req1_ready, req0_ready}, (k % 2 == 1) ? 64'd2 : 64'd1);
      tick();
      check("cont_ready_run", {62'd0, req1_ready, req0_ready}, 64'd0);
      wait_resp(cyc);
      check("cont_latency", 64'(cyc), 64'd3);
      check("cont_id", 64'(resp_id), (k % 2 == 1) ? 64'd1 : 64'd0);
      check("cont_result", resp_result, (k % 2 == 1) ? 64'd143 : 64'd15);
      check("cont_ready_clr", {62'd0, req1_ready, req0_ready}, 64'd0);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    // Single op 7 x 9.
    start_op(0, 32'd7, 32'd9, 3);
    finish_op(1'b0, 64'd63, 1'b0, 5, 32'd7);

    // Valid withdrawn before any edge: no side effect.
    req1_valid = 1'b1;
    #1;
    req1_valid = 1'b0;
    tick();
    check("glitch_busy", 64'(busy), 64'd0);
    check("glitch_start", 64'(mul_op_start), 64'd0);

    // Timeout: multiplier never answers.
    start_op(0, 32'd5, 32'd6, 200);
    finish_op(1'b0, 64'd0, 1'b1, 10, 32'd5);

    // Race: done arrives when the counter is TIMEOUT-1.
    start_op(1, 32'd1000, 32'd1000, 8);
    finish_op(1'b1, 64'd1000000, 1'b0, 10, 32'd1000);

    // Boundary operands.
    start_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    finish_op(1'b0, 64'hFFFF_FFFE_0000_0001, 1'b0, 3, 32'hFFFF_FFFF);

    // Reset in the middle of RUN.
    start_op(0, 32'd4, 32'd4, 200);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("rrun_start", 64'(mul_op_start), 64'd0);
    check("rrun_busy", 64'(busy), 64'd0);
    check("rrun_mul_a", 64'(mul_multiplier), 64'd0);
    check("rrun_result", resp_result, 64'd0);
    check("rrun_valid_err", {62'd0, resp_valid, resp_error}, 64'd0);
    reset = 1'b0;
    saw_resp = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      saw_resp = saw_resp | resp_valid;
    end
    check("rrun_no_resp", 64'(saw_resp), 64'd0);
    start_op(1, 32'd12, 32'd12, 2);
    finish_op(1'b1, 64'd144, 1'b0, 4, 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 100, max cycles waited for mul_op_done before abort (range 2..127).
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req0_valid  in  1  requester 0 has an operation pending.
REQ-005 req0_ready  out  1  requester 0 accepted this cycle when req0_valid is also high.
REQ-006 req0_multiplier, req0_multiplicand  in  32 each  requester 0 operands.
REQ-007 req1_valid / req1_ready / req1_multiplier / req1_multiplicand  same as REQ-004..006, requester 1.
REQ-008 resp_valid  out  1  one-cycle pulse: response available.
REQ-009 resp_id  out  1  requester that owns the response.
REQ-010 resp_result  out  64  unsigned product.
REQ-011 resp_error  out  1  high when the response is a timeout abort.
REQ-012 mul_multiplier, mul_multiplicand  out  32 each  operands to the shared multiplier.
REQ-013 mul_op_start  out  1  start level to the multiplier.
REQ-014 mul_op_clear  out  1  clear pulse to the multiplier.
REQ-015 mul_op_done  in  1  multiplier done level; held until clear.
REQ-016 mul_result  in  64  multiplier product, valid while mul_op_done is high.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, RUN, CLEAR; encoding from the shared package.
REQ-019 In IDLE, ready SHALL be combinationally asserted to exactly one valid requester; never both.
REQ-020 Single valid requester SHALL be granted; both valid SHALL grant the one not granted last (round-robin); last-grant pointer resets to 1, so requester 0 wins first contention.
REQ-021 On accept (valid & ready, cycle T): operands and id SHALL be registered; state -> RUN at T+1; mul_op_start SHALL be 1 from T+1.
REQ-022 mul_multiplier/mul_multiplicand SHALL stay stable from T+1 until CLEAR exits.
REQ-023 In RUN, a 7-bit wait counter SHALL increment each cycle from 0.
REQ-024 When mul_op_done=1 in RUN (cycle D): resp_result <= mul_result, resp_error <= 0, resp_valid=1 at D+1, state -> CLEAR.
REQ-025 If counter reaches TIMEOUT-1 with mul_op_done=0: resp_result <= 0, resp_error <= 1, resp_valid=1 next cycle, state -> CLEAR.
REQ-026 Done and timeout in the same cycle: done SHALL win (no error).
REQ-027 CLEAR SHALL last exactly one cycle: mul_op_start=0, mul_op_clear=1; then IDLE.
REQ-028 Earliest next accept SHALL be at D+2; ready SHALL be 0 in RUN and CLEAR.
REQ-029 resp_result/resp_id/resp_error SHALL hold until the next response; resp_valid is a single-cycle pulse.
REQ-030 Requester deasserting valid while not accepted SHALL cause no side effect.

Reset
REQ-031 On reset: state IDLE, counter 0, last-grant 1, and all outputs 0 (req*_ready, resp_*, mul_*, busy).
REQ-032 Reset mid-RUN SHALL abandon the operation with no response; mul_op_start drops at the next edge.

Structure
REQ-033 Package mul_arb_pkg SHALL hold the state typedef/encoding, the TIMEOUT default and the operand/result width constants (32/64).
REQ-034 Round-robin grant logic SHALL be a sub-module rr_arbiter2 (2 requests, last-grant pointer, update on accept).

Verification
REQ-035 Single: req0 valid, 7 x 9 -> mul_op_start from T+1; after done, resp_valid pulse, resp_id=0, resp_result=63, resp_error=0; one-cycle mul_op_clear.
REQ-036 Contention: both valid continuously, four ops -> grants in order 0,1,0,1; each resp_id matches its product.
REQ-037 Timeout: model holds mul_op_done=0, TIMEOUT=10 -> resp_valid 10 cycles into RUN, resp_error=1, resp_result=0, then CLEAR.
REQ-038 Race: mul_op_done rises on counter=TIMEOUT-1 -> resp_error=0, correct product.
REQ-039 Boundary: 0xFFFFFFFF x 0xFFFFFFFF -> resp_result=0xFFFFFFFE00000001.
REQ-040 Reset in RUN -> next cycle all outputs 0, no resp_valid; subsequent req1 op completes correctly.
